parking_system: RTL and testbench



---
 rtl/parking_system.sv | 119 +++++++++++
 tb/tb_parking_system.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/parking_system.sv
// -----------------------------------------------------------------------------
// parking_system
//
// Gate controller for a single-lane car park entrance. A car at the entrance
// sensor starts a password window. The password on the keypad is judged at the
// last edge of that window: a match opens the gate, and a miss holds it shut
// until the keypad shows the right value. A second car arriving while the gate
// is open (both sensors high) blocks the gate until the password is matched
// again. State is shown on two active-low 7-segment digits.
//
// Parameters
//   PASSWORD     accepted 2-bit password value
//   WAIT_CYCLES  cycles spent waiting before the password is judged (1..255)
//
// Ports
//   clk              rising-edge clock for all state
//   reset_n          synchronous reset, ACTIVE HIGH despite the name (1 = reset)
//   sensor_entrance  car present at the entrance (level)
//   sensor_exit      car has passed the gate (level)
//   password_1       keypad password value (level)
//   HEX_1            left digit,  active-low segments {g,f,e,d,c,b,a}
//   HEX_2            right digit, same encoding
// -----------------------------------------------------------------------------
module parking_system #(
  parameter logic [1:0] PASSWORD    = 2'b10,
  parameter int         WAIT_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sensor_entrance,
  input  logic       sensor_exit,
  input  logic [1:0] password_1,
  output logic [6:0] HEX_1,
  output logic [6:0] HEX_2
);

  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    WAIT_PASSWORD = 3'd1,
    WRONG_PASS    = 3'd2,
    RIGHT_PASS    = 3'd3,
    STOP          = 3'd4
  } state_t;

  // Counter value at which the password is judged.
  localparam logic [7:0] LAST_COUNT = 8'(WAIT_CYCLES - 1);

  // Segment patterns, active low {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_N     = 7'b0101011;
  localparam logic [6:0] SEG_G     = 7'b0000010;
  localparam logic [6:0] SEG_O     = 7'b1000000;
  localparam logic [6:0] SEG_S     = 7'b0010010;
  localparam logic [6:0] SEG_P     = 7'b0001100;

  state_t     state_q, state_d;
  logic [7:0] count_q, count_d;
  logic       match;

  assign match = (password_1 == PASSWORD);

  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_q <= IDLE;
      count_q <= 8'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next-state logic. The counter only ever runs in WAIT_PASSWORD, so it
  // defaults to zero and every other state simply leaves it cleared.
  always_comb begin
    state_d = state_q;
    count_d = 8'd0;
    unique case (state_q)
      IDLE: begin
        if (sensor_entrance) state_d = WAIT_PASSWORD;
      end
      WAIT_PASSWORD: begin
        // ">=" rather than "==" so a stray count can never stall here.
        if (count_q < LAST_COUNT) begin
          count_d = count_q + 8'd1;
        end else begin
          state_d = match ? RIGHT_PASS : WRONG_PASS;
        end
      end
      WRONG_PASS: begin
        if (match) state_d = RIGHT_PASS;
      end
      RIGHT_PASS: begin
        // Tailgating (both sensors) wins over a normal exit.
        if (sensor_entrance && sensor_exit) state_d = STOP;
        else if (sensor_exit)               state_d = IDLE;
      end
      STOP: begin
        if (match) state_d = RIGHT_PASS;
      end
      default: state_d = IDLE;  // unused encodings recover to IDLE
    endcase
  end

  // Moore output decode straight from the state register.
  always_comb begin
    HEX_1 = SEG_BLANK;
    HEX_2 = SEG_BLANK;
    unique case (state_q)
      IDLE:          begin HEX_1 = SEG_BLANK; HEX_2 = SEG_BLANK; end
      WAIT_PASSWORD: begin HEX_1 = SEG_E;     HEX_2 = SEG_N;     end
      WRONG_PASS:    begin HEX_1 = SEG_E;     HEX_2 = SEG_E;     end
      RIGHT_PASS:    begin HEX_1 = SEG_G;     HEX_2 = SEG_O;     end
      STOP:          begin HEX_1 = SEG_S;     HEX_2 = SEG_P;     end
      default:       begin HEX_1 = SEG_BLANK; HEX_2 = SEG_BLANK; end
    endcase
  end

endmodule

// File: tb/tb_parking_system.sv
// -----------------------------------------------------------------------------
// tb_parking_system
//
// Directed bench for parking_system. Inputs change 1 time unit after a rising
// edge and outputs are read at the same point, so every check sees the state
// produced by the edge just taken. Expected digit pairs are fixed constants.
// -----------------------------------------------------------------------------
module tb_parking_system;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       sensor_entrance;
  logic       sensor_exit;
  logic [1:0] password_1;
  logic [6:0] HEX_1;
  logic [6:0] HEX_2;

  int checks   = 0;
  int failures = 0;

  // {HEX_1, HEX_2} expected pairs.
  localparam logic [13:0] BLANK = {7'b1111111, 7'b1111111};
  localparam logic [13:0] EN    = {7'b0000110, 7'b0101011};
  localparam logic [13:0] EE    = {7'b0000110, 7'b0000110};
  localparam logic [13:0] GO    = {7'b0000010, 7'b1000000};
  localparam logic [13:0] SP    = {7'b0010010, 7'b0001100};

  parking_system dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .sensor_entrance (sensor_entrance),
    .sensor_exit     (sensor_exit),
    .password_1      (password_1),
    .HEX_1           (HEX_1),
    .HEX_2           (HEX_2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [13:0] expected);
    checks++;
    assert ({HEX_1, HEX_2} === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, {HEX_1, HEX_2}, expected);
    end
  endtask

  initial begin
    reset_n         = 1'b1;
    sensor_entrance = 1'b0;
    sensor_exit     = 1'b0;
    password_1      = 2'b00;

    // Reset held for two edges with random inputs.
    tick();
    sensor_entrance = 1'($urandom);
    sensor_exit     = 1'($urandom);
    password_1      = 2'($urandom);
    tick();
    check("reset_edge2", BLANK);
    reset_n         = 1'b0;
    sensor_entrance = 1'b0;
    sensor_exit     = 1'b1;
    password_1      = 2'b10;
    tick();
    check("idle_after_release", BLANK);
    tick();
    check("idle_ignores_exit_pw", BLANK);
    sensor_exit = 1'b0;

    // Correct entry: three cycles of "En", then "GO".
    sensor_entrance = 1'b1;
    password_1      = 2'b10;
    tick();
    check("ok_wait1", EN);
    sensor_entrance = 1'b0;
    tick();
    check("ok_wait2", EN);
    tick();
    check("ok_wait3", EN);
    tick();
    check("ok_open", GO);
    password_1 = 2'b01;
    tick();
    check("open_ignores_pw", GO);
    sensor_exit = 1'b1;
    tick();
    check("ok_exit", BLANK);
    sensor_exit = 1'b0;

    // Wrong then correct.
    sensor_entrance = 1'b1;
    password_1      = 2'b01;
    tick();
    check("wr_wait1", EN);
    sensor_entrance = 1'b0;
    tick();
    check("wr_wait2", EN);
    tick();
    check("wr_wait3", EN);
    tick();
    check("wr_wrong", EE);
    sensor_entrance = 1'b1;
    sensor_exit     = 1'b1;
    tick();
    check("wr_hold1", EE);
    sensor_entrance = 1'b0;
    sensor_exit     = 1'b0;
    tick();
    check("wr_hold2", EE);
    password_1 = 2'b10;
    tick();
    check("wr_fixed", GO);

    // Tailgate from RIGHT_PASS.
    sensor_entrance = 1'b1;
    sensor_exit     = 1'b1;
    password_1      = 2'b01;
    tick();
    check("tg_stop", SP);
    sensor_entrance = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("tg_hold%0d", i), SP);
    end
    sensor_exit = 1'b0;
    password_1  = 2'b10;
    tick();
    check("tg_release", GO);
    sensor_exit = 1'b1;
    tick();
    check("tg_exit", BLANK);
    sensor_exit = 1'b0;

    // Password valid early in the window but wrong at the final edge.
    sensor_entrance = 1'b1;
    password_1      = 2'b10;
    tick();
    check("late_wait1", EN);
    sensor_entrance = 1'b0;
    tick();
    check("late_wait2", EN);
    tick();
    check("late_wait3", EN);
    password_1 = 2'b00;
    tick();
    check("late_wrong", EE);
    password_1 = 2'b10;
    tick();
    check("late_fixed", GO);
    sensor_exit = 1'b1;
    tick();
    check("late_exit", BLANK);
    sensor_exit = 1'b0;

    // Reset during the second wait cycle discards the count.
    sensor_entrance = 1'b1;
    tick();
    check("rw_wait1", EN);
    sensor_entrance = 1'b0;
    tick();
    check("rw_wait2", EN);
    reset_n = 1'b1;
    tick();
    check("rw_reset", BLANK);
    reset_n = 1'b0;

    // Fresh entry still takes the full three wait cycles.
    sensor_entrance = 1'b1;
    tick();
    check("fresh_wait1", EN);
    sensor_entrance = 1'b0;
    tick();
    check("fresh_wait2", EN);
    tick();
    check("fresh_wait3", EN);
    tick();
    check("fresh_open", GO);

    // Reset from STOP.
    sensor_entrance = 1'b1;
    sensor_exit     = 1'b1;
    tick();
    check("rs_stop", SP);
    sensor_entrance = 1'b0;
    sensor_exit     = 1'b0;
    reset_n         = 1'b1;
    tick();
    check("rs_reset", BLANK);
    reset_n = 1'b0;
    tick();
    check("rs_idle", BLANK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
